// File: rtl/gpia_in_port.sv
// GPIA input port: pin synchroniser, edge-to-event latch, Wishbone register slave and IRQ.
// Optional macro GPIA_IN_FILTER_EN adds a 3-sample stability filter ahead of edge detection.
module gpia_in_port #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             res_i,
    input  logic [WIDTH-1:0] p_i,
    input  logic [1:0]       adr_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic [WIDTH-1:0] dat_o,
    input  logic             we_i,
    input  logic             stb_i,
    output logic             ack_o,
    output logic             irq_o
);

    localparam logic [1:0] ADR_LEVEL   = 2'd0;
    localparam logic [1:0] ADR_EVENT   = 2'd1;
    localparam logic [1:0] ADR_RISE_EN = 2'd2;
    localparam logic [1:0] ADR_FALL_EN = 2'd3;

    logic [WIDTH-1:0] sync0_q, sync0_d;
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [WIDTH-1:0] ev_q, ev_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] dat_q, dat_d;
    logic             ack_q, ack_d;

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] rd_data;
    logic             access;
    logic             wr;

`ifdef GPIA_IN_FILTER_EN
    logic [WIDTH-1:0] hist1_q, hist1_d;
    logic [WIDTH-1:0] hist2_q, hist2_d;
    logic [WIDTH-1:0] filt_q, filt_d;
    logic [WIDTH-1:0] stable;

    // Filtered level follows sync1 only once it has agreed over three consecutive samples.
    always_comb begin
        hist1_d = sync1_q;
        hist2_d = hist1_q;
        stable  = ~(sync1_q ^ hist1_q) & ~(sync1_q ^ hist2_q);
        filt_d  = (filt_q & ~stable) | (sync1_q & stable);
        level   = filt_q;
    end

    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) begin
            hist1_q <= '0;
            hist2_q <= '0;
            filt_q  <= '0;
        end else begin
            hist1_q <= hist1_d;
            hist2_q <= hist2_d;
            filt_q  <= filt_d;
        end
    end
`else
    always_comb begin
        level = sync1_q;
    end
`endif

    always_comb begin
        case (adr_i)
            ADR_LEVEL:   rd_data = level;
            ADR_EVENT:   rd_data = ev_q;
            ADR_RISE_EN: rd_data = rise_en_q;
            default:     rd_data = fall_en_q;
        endcase
    end

    // Next-state logic; an access is taken only while ack is low, giving the two-cycle handshake.
    always_comb begin
        sync0_d   = p_i;
        sync1_d   = sync0_q;
        last_d    = level;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        dat_d     = dat_q;
        ack_d     = 1'b0;
        clr       = '0;

        access = stb_i & ~ack_q;
        wr     = access & we_i;

        rise = level & ~last_q & rise_en_q;
        fall = ~level & last_q & fall_en_q;

        if (access) begin
            ack_d = 1'b1;
            dat_d = we_i ? '0 : rd_data;
        end

        if (wr) begin
            case (adr_i)
                ADR_EVENT:   clr       = dat_i;
                ADR_RISE_EN: rise_en_d = dat_i;
                ADR_FALL_EN: fall_en_d = dat_i;
                default:     ;
            endcase
        end

        // New edges win over a same-cycle clear so no event is dropped.
        ev_d = (ev_q & ~clr) | rise | fall;
    end

    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) begin
            sync0_q   <= '0;
            sync1_q   <= '0;
            last_q    <= '0;
            ev_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            dat_q     <= '0;
            ack_q     <= 1'b0;
        end else begin
            sync0_q   <= sync0_d;
            sync1_q   <= sync1_d;
            last_q    <= last_d;
            ev_q      <= ev_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            dat_q     <= dat_d;
            ack_q     <= ack_d;
        end
    end

    assign dat_o = dat_q;
    assign ack_o = ack_q;
    assign irq_o = |ev_q;

endmodule

// File: doc/gpia_in_port.md
Name: gpia_in_port

Overview:
- Input-side companion to the GPIA output bits: samples WIDTH external pins and synchronises them into the system clock domain.
- Detects rising and falling edges and latches enabled edges into sticky event bits.
- Exposes level, event and mask registers to the CPU over a single-cycle-acknowledge Wishbone slave.
- Drives an interrupt request to the Kestrel-3 interrupt logic.

Parameters:
- WIDTH, 8, number of input pins and data bus width (1..32).

Ports:
- clk_i  in  1  system clock (12.5 MHz nominal); all logic on rising edge
- res_i  in  1  reset, asynchronous, active-low; all registers clear while low
- p_i  in  WIDTH  external pins, asynchronous to clk_i
- adr_i  in  2  register select
- dat_i  in  WIDTH  write data
- dat_o  out  WIDTH  read data, registered
- we_i  in  1  1 = write, 0 = read
- stb_i  in  1  bus strobe (cycle request)
- ack_o  out  1  bus acknowledge, registered
- irq_o  out  1  interrupt request, OR of all event bits

Behaviour:
- Reset (res_i low): sync0, sync1, last, ev, rise_en, fall_en, dat_o, ack_o all 0. irq_o therefore 0. Reset mid-transaction aborts it; no ack is issued for it.
- Synchroniser: sync0 <= p_i; sync1 <= sync0; last <= sync1, every clock.
- Edge terms (combinational):
  - rise = sync1 & ~last & rise_en
  - fall = ~sync1 & last & fall_en
- Event latch, per bit: ev <= (ev & ~clr) | rise | fall.
  - clr = dat_i when a write to adr 1 is acknowledged this edge, else 0.
  - Set has priority over clear in the same cycle, so an event is never lost.
- Latency: a pin change stable before edge k gives sync1 at edge k+1, ev bit at edge k+2, irq_o high after edge k+2.
- Register map:
  - 0 = LEVEL: read-only; returns sync1; writes ignored but acknowledged.
  - 1 = EVENT: read returns ev; write-1-to-clear, write-0 has no effect.
  - 2 = RISE_EN: read/write.
  - 3 = FALL_EN: read/write.
- Enable changes affect only future edges. Clearing an enable does not clear pending ev bits.
- Bus handshake:
  - Edge with stb_i=1 and ack_o=0: perform the access, load dat_o (reads; writes load 0), set ack_o=1.
  - Next edge: ack_o=0 unconditionally.
  - Every access therefore takes exactly 2 cycles. Back-to-back: a held stb_i gets a new ack every other cycle.
  - dat_o holds its last value when not acknowledging.
  - Writes update the register on the same edge ack_o rises.
- irq_o = |ev, combinational from registered ev (glitch-free).
- Pins held high across reset release: no event is latched, since enables are 0. After an enable is set, only subsequent transitions latch.

Optional Feature:
- Macro GPIA_IN_FILTER_EN.
- Defined:
  - Adds a per-bit 3-sample stability filter between sync1 and the edge detector.
  - The filtered level changes only after sync1 holds a new value for 3 consecutive clocks.
  - LEVEL reads the filtered value.
  - Event latency becomes k+5.
  - Pulses shorter than 3 clocks are ignored.
  - Filter state resets to 0.
- Undefined: no filter; latency k+2; single-cycle pulses (≥1 clock wide, captured by sync0) produce events.

Test Plan:
- Reset: res_i low with p_i=8'hFF, then release; read adr 0 -> 8'hFF after ≥2 clocks. Read adr 1 -> 8'h00, irq_o=0, ack_o pulses for exactly one cycle per read.
- Rising edge: write adr 2 = 8'h01, drive p_i[0] 0->1 -> ev[0]=1 two edges later. irq_o=1; read adr 1 -> 8'h01.
- W1C: from the previous state, write adr 1 = 8'h00 -> ev unchanged. Write 8'h01 -> ev=0, irq_o=0.
- Simultaneous set/clear: with fall_en[3]=1, drop p_i[3] timed so the falling edge lands on the same edge as a write adr 1 = 8'h08 -> ev[3] remains 1.
- Masked edges: enables 0, toggle p_i=8'hAA/8'h55 -> ev stays 8'h00. Set fall_en=8'h0F, pins 8'hFF->8'h00 -> ev=8'h0F.
- Filter (GPIA_IN_FILTER_EN): a 2-cycle high pulse on p_i[1] with rise_en[1]=1 -> no event. A 4-cycle pulse -> ev[1]=1 five edges after the rise.
